multi_debounce: RTL and testbench
=================================

# multi_debounce

Parametrised N-channel input conditioner for board push-buttons and switches: per-channel synchroniser, debounce filter, one-cycle edge pulses and optional auto-repeat. It sits between raw board pins such as KEY and SW and the CPU/datapath control logic. It replaces ad-hoc per-pin synchroniser/debounce/edge-detect chains, adding a channel count, an input polarity mode, reset and repeat generation.

## Interface
- N, 4, number of independent channels
- CLK_FREQ_HZ, 50_000_000, clock frequency
- DEBOUNCE_MS, 30, required stable time before the output follows the input
- SYNC_STAGES, 2, synchroniser flop depth (>=2)
- ACTIVE_LOW, 1, 1 = input inverted before sync, so y=1 means pressed
- REPEAT_DELAY_MS, 500, press-to-first-repeat time (used only with the repeat feature)
- REPEAT_RATE_MS, 100, interval between repeats (used only with the repeat feature)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- x  input  N  raw asynchronous pin levels
- y  output  N  debounced level, registered
- rise  output  N  one-cycle pulse on y 0->1
- fall  output  N  one-cycle pulse on y 1->0
- rep  output  N  one-cycle auto-repeat pulse (all zero when the feature is compiled out)

## Operation
- Per channel: xi = ACTIVE_LOW ? ~x[i] : x[i]. xi passes through a SYNC_STAGES-deep flop chain to give s.
- Debounce period: PERIOD = CLK_FREQ_HZ/1000*DEBOUNCE_MS cycles.
- Counter width: $clog2(PERIOD+1).
- Counter rule, evaluated each cycle:
  - s==y: counter clears to 0.
  - s!=y and cnt<PERIOD-1: cnt increments.
  - s!=y and cnt==PERIOD-1: y toggles, cnt clears.
- Any single cycle with s==y restarts the wait, so glitches shorter than PERIOD never reach y.
- rise[i]/fall[i] are registered and high exactly in the first cycle y[i] shows its new value.
- Channels are fully independent; simultaneous transitions on several channels are each handled normally.
- Reset, asserted at any time: sync chain, counters, y, rise, fall, rep and repeat state all go to 0 immediately, with no pulse emitted.
- After reset release with a pressed input: the channel sees s!=y and produces a rise after the normal debounce time.

## Timing
- Input-to-y latency: SYNC_STAGES + PERIOD cycles of stable input.
- rise/fall: zero cycles relative to the y edge.
- Minimum gap between consecutive y toggles on one channel: PERIOD cycles.
- Counter never exceeds PERIOD-1; no wrap-around.

## Configuration
- Macro: MULTI_DEBOUNCE_REPEAT_EN.
- Defined: one repeat counter per channel.
  - Counter clears on rise and counts while y=1.
  - rep pulses at REPEAT_DELAY cycles after rise, then every REPEAT_RATE cycles while y stays 1.
  - rep is never asserted in the rise cycle.
  - fall or reset clears the counter and stops repeats; no rep in the fall cycle.
  - Cycle counts: REPEAT_DELAY = CLK_FREQ_HZ/1000*REPEAT_DELAY_MS, REPEAT_RATE = CLK_FREQ_HZ/1000*REPEAT_RATE_MS.
- Undefined: rep tied to 0; no repeat registers synthesised.

## Structure
- Shared package holds:
  - the ms-to-cycles conversion function;
  - default constants (CLK_FREQ_HZ = 50_000_000, default debounce and repeat ms values).
- Sub-module debounce_channel covers one channel: sync, counter, y, edge pulses and repeat.
- multi_debounce is a generate loop of N debounce_channel instances plus the polarity inversion.

## Test plan
Bench parameters: N=2, CLK_FREQ_HZ=1000, DEBOUNCE_MS=4, SYNC_STAGES=2, ACTIVE_LOW=0. This gives PERIOD=4.

- Clean press: x[0] 0->1 and held -> y[0]=1 and rise[0]=1 exactly 6 cycles later; rise lasts 1 cycle; fall stays 0.
- Glitch rejection: x[0] high for 3 cycles then low -> y[0] stays 0; no pulses.
- Bounce: x[0] pattern 1,0,1,1,0 then steady 1 -> y[0] rises 6 cycles after the last 0->1 transition.
- Channel independence: x[1] pressed 2 cycles after x[0] -> rise[1] exactly 2 cycles after rise[0]; both y=1.
- Reset mid-count: x[0]=1, reset pulsed at cycle 3 of the count -> all outputs 0 during and after reset; rise[0] 6 cycles after release.
- Repeat (macro defined; REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3) with press held -> rep[0] at 10, 13 and 16 cycles after rise[0]; release -> no further rep after fall[0].
- Polarity (ACTIVE_LOW=1) with x[0] held low -> y[0]=1 after 6 cycles.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared constants, types and the ms-to-cycles helper for multi_debounce.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multi_debounce_pkg;

    localparam int DEF_CLK_FREQ_HZ     = 50_000_000;
    localparam int DEF_DEBOUNCE_MS     = 30;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_RATE_MS  = 100;

    // Per-channel conditioned outputs, bundled so the top can fan them out.
    typedef struct packed {
        logic y;
        logic rise;
        logic fall;
        logic rep;
    } chan_out_t;

    // Whole-kHz division first so 50 MHz * 500 ms stays inside 32 bits.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser, debounce counter, registered level, edge and repeat pulses.
// Latency: SYNC_STAGES + PERIOD cycles from a stable input to y; rise/fall/rep align with y.
// Backpressure: none; free-running conditioner, outputs are plain levels/pulses.
//
// Ports: clk, reset (async, active-high), xi (polarity-corrected raw pin),
//        o (chan_out_t: y level, rise/fall/rep one-cycle pulses).
// Optional auto-repeat is compiled in with MULTI_DEBOUNCE_REPEAT_EN.
module debounce_channel
    import multi_debounce_pkg::*;
#(
    parameter int PERIOD       = 4,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      xi,
    output chan_out_t o
);

    localparam int CW = $clog2(PERIOD + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   y;
    logic                   rise;
    logic                   fall;
    logic                   rep;
    logic                   s;
    logic                   hit;

    assign s   = sync[SYNC_STAGES-1];
    // hit marks the cycle in which y flips; everything else keys off it.
    assign hit = (s != y) && (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            y    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], xi};
            rise <= hit & ~y;
            fall <= hit & y;
            if (s == y) begin
                // Any agreeing sample restarts the wait, filtering short glitches.
                cnt <= '0;
            end else if (hit) begin
                cnt <= '0;
                y   <= ~y;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rnxt;
    logic [RW-1:0] rtarget;
    logic          rate_phase;

    assign rnxt    = rcnt + 1'b1;
    // First interval after the press is the long delay, then the short rate.
    assign rtarget = rate_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt       <= '0;
            rate_phase <= 1'b0;
            rep        <= 1'b0;
        end else if (!y || hit) begin
            // Released, rising or falling this cycle: hold idle, no pulse.
            rcnt       <= '0;
            rate_phase <= 1'b0;
            rep        <= 1'b0;
        end else if (rnxt == rtarget) begin
            rcnt       <= '0;
            rate_phase <= 1'b1;
            rep        <= 1'b1;
        end else begin
            rcnt <= rnxt;
            rep  <= 1'b0;
        end
    end
`else
    // Repeat timing has no effect in this build; rep is a hard zero.
    assign rep = 1'b0 & |{REPEAT_DELAY, REPEAT_RATE};
`endif

    assign o = '{y: y, rise: rise, fall: fall, rep: rep};

endmodule

// File: rtl/multi_debounce.sv
// N-channel push-button/switch conditioner: polarity fix, sync, debounce, edge and repeat pulses.
// Latency: SYNC_STAGES + PERIOD cycles of stable input to y; rise/fall coincide with the y edge.
// Backpressure: none; every channel runs independently every cycle.
//
// Ports: clk; reset (async, active-high); x[N] raw pins;
//        y[N] debounced level; rise/fall[N] edge pulses; rep[N] auto-repeat pulses.
// Auto-repeat is compiled in with MULTI_DEBOUNCE_REPEAT_EN; otherwise rep is all zero.
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int N               = 4,
    parameter int CLK_FREQ_HZ     = DEF_CLK_FREQ_HZ,
    parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] rep
);

    localparam int PERIOD       = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int REPEAT_DELAY = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
    localparam int REPEAT_RATE  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);

    logic [N-1:0] xi;

    // Normalise so a 1 always means "pressed" from here on.
    assign xi = ACTIVE_LOW ? ~x : x;

    for (genvar i = 0; i < N; i++) begin : g_ch
        chan_out_t ch_out;

        debounce_channel #(
            .PERIOD       (PERIOD),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .xi    (xi[i]),
            .o     (ch_out)
        );

        assign y[i]    = ch_out.y;
        assign rise[i] = ch_out.rise;
        assign fall[i] = ch_out.fall;
        assign rep[i]  = ch_out.rep;
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: scoreboard of expected rise/fall events per cycle.
// Latency: expects pulses SYNC_STAGES + PERIOD = 6 cycles after a stable input change.
// Backpressure: n/a.
module tb_multi_debounce;

    localparam int N         = 2;
    localparam int LAT       = 6;
    localparam int REP_DELAY = 10;
    localparam int REP_RATE  = 3;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] x     = '0;
    logic [N-1:0] x_al  = '1;
    logic [N-1:0] y, rise, fall, rep;
    logic [N-1:0] y_al, rise_al, fall_al, rep_al;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] r;
        logic [N-1:0] f;
    } ev_t;

    ev_t          exp_q[$];
    int           al_q[$];
    logic [N-1:0] y_exp = '0;
    int           rise_cyc[N];

    multi_debounce #(
        .N(N), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(2), .ACTIVE_LOW(0),
        .REPEAT_DELAY_MS(REP_DELAY), .REPEAT_RATE_MS(REP_RATE)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .rise(rise), .fall(fall), .rep(rep)
    );

    multi_debounce #(
        .N(N), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1),
        .REPEAT_DELAY_MS(REP_DELAY), .REPEAT_RATE_MS(REP_RATE)
    ) dut_al (
        .clk(clk), .reset(reset), .x(x_al), .y(y_al), .rise(rise_al), .fall(fall_al), .rep(rep_al)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(int c, logic [N-1:0] r, logic [N-1:0] f);
        exp_q.push_back('{cyc: c, r: r, f: f});
    endfunction

    // Pops events due this cycle and returns expected {y, rise, fall, rep}.
    // Repeats follow the spec's timing: rise + DELAY + k*RATE while still held.
    function automatic logic [4*N-1:0] model_step();
        logic [N-1:0] r = '0;
        logic [N-1:0] f = '0;
        logic [N-1:0] p = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                r |= exp_q[i].r;
                f |= exp_q[i].f;
                exp_q.delete(i);
            end
        end
        y_exp = (y_exp | r) & ~f;
        for (int ch = 0; ch < N; ch++) begin
            if (r[ch]) begin
                rise_cyc[ch] = cyc;
            end else if (REP_EN && y_exp[ch] && (cyc - rise_cyc[ch]) >= REP_DELAY &&
                         ((cyc - rise_cyc[ch] - REP_DELAY) % REP_RATE) == 0) begin
                p[ch] = 1'b1;
            end
        end
        return {y_exp, r, f, p};
    endfunction

    task automatic test_reset();
        logic [4*N-1:0] ev;
        #2 reset = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev || {y_al, rise_al, fall_al} !== '0) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got y=%b r=%b f=%b p=%b al_y=%b want %b", cyc, y, rise, fall, rep, y_al, ev);
            end
            if (t == 3) reset = 1'b0;
        end
    endtask

    task automatic test_clean_press();
        logic [4*N-1:0] ev;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL clean_press cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t == 0)  begin x[0] = 1'b1; push_ev(cyc + LAT, 2'b01, 2'b00); end
            if (t == 10) begin x[0] = 1'b0; push_ev(cyc + LAT, 2'b00, 2'b01); end
        end
    endtask

    task automatic test_glitch();
        logic [4*N-1:0] ev;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t == 0) x[0] = 1'b1;
            if (t == 3) x[0] = 1'b0;
        end
    endtask

    task automatic test_bounce();
        logic [4*N-1:0] ev;
        logic [5:0]     pat;
        pat = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL bounce cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t < 6) x[0] = pat[t];
            if (t == 5)  push_ev(cyc + LAT, 2'b01, 2'b00);
            if (t == 15) begin x[0] = 1'b0; push_ev(cyc + LAT, 2'b00, 2'b01); end
        end
    endtask

    task automatic test_independence();
        logic [4*N-1:0] ev;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL independence cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t == 0) begin x[0] = 1'b1; push_ev(cyc + LAT, 2'b01, 2'b00); end
            if (t == 2) begin x[1] = 1'b1; push_ev(cyc + LAT, 2'b10, 2'b00); end
        end
    endtask

    task automatic test_reset_mid();
        logic [4*N-1:0] ev;
        for (int t = 0; t < 28; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t == 0)  begin x[0] = 1'b0; push_ev(cyc + LAT, 2'b00, 2'b01); end
            if (t == 10) begin x[0] = 1'b1; push_ev(cyc + LAT, 2'b01, 2'b00); end
            if (t == 13) begin
                reset = 1'b1;
                exp_q.delete();
                y_exp = '0;
                #1;
                vectors++;
                if ({y, rise, fall, rep} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_async cyc=%0d got y=%b r=%b f=%b p=%b want all 0", cyc, y, rise, fall, rep);
                end
            end
            if (t == 15) begin reset = 1'b0; push_ev(cyc + LAT, 2'b11, 2'b00); end
        end
    endtask

    task automatic test_repeat();
        logic [4*N-1:0] ev;
        int             r_cyc;
        r_cyc = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ev = model_step();
            vectors++;
            if ({y, rise, fall, rep} !== ev) begin
                miscompares++;
                $display("FAIL repeat cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y, rise, fall, rep, ev);
            end
            if (t == 0) begin x = 2'b00; push_ev(cyc + LAT, 2'b00, 2'b11); end
            if (t == 10) begin
                x[0]  = 1'b1;
                r_cyc = cyc + LAT;
                push_ev(r_cyc, 2'b01, 2'b00);
            end
            // Release so the fall lands exactly on what would be a repeat slot.
            if (t > 10 && cyc == r_cyc + REP_DELAY + 3 * REP_RATE) begin
                x[0] = 1'b0;
                push_ev(cyc + LAT, 2'b00, 2'b01);
            end
        end
    endtask

    task automatic test_polarity();
        logic [3*N-1:0] ev;
        logic [N-1:0]   y_al_exp;
        logic [N-1:0]   r_al_exp;
        y_al_exp = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            r_al_exp = '0;
            if (al_q.size() > 0 && al_q[0] == cyc) begin
                void'(al_q.pop_front());
                r_al_exp = 2'b01;
                y_al_exp = 2'b01;
            end
            ev = {y_al_exp, r_al_exp, 2'b00};
            vectors++;
            if ({y_al, rise_al, fall_al} !== ev) begin
                miscompares++;
                $display("FAIL polarity cyc=%0d got y=%b r=%b f=%b p=%b want %b", cyc, y_al, rise_al, fall_al, rep_al, ev);
            end
            if (t == 0) begin x_al[0] = 1'b0; al_q.push_back(cyc + LAT); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_independence();
        test_reset_mid();
        test_repeat();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
